// File: rtl/seq_magnitude_comparator.sv
// Purpose : multi-cycle WIDTH-bit magnitude comparator, one DIGIT-bit slice per
//           clock from the MSB slice down, unsigned or two's complement.
// Latency : done is high k cycles after the accept edge, where k is the
//           number of slices examined (1..NDIG). No idle cycle is needed
//           between operations.
// Backpressure: none. start is ignored while busy and accepted in IDLE or DONE.
//           Results hold until the next accept or reset.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request; a, b and signed_mode are latched when it is accepted
//   signed_mode       1 = operands are two's complement
//   a, b              WIDTH-bit operands
//   busy              high while slices are being compared
//   done              one-cycle pulse when the result is final
//   gt, lt, eq        one-hot result, held after done
//   ndig_used         number of slices examined for the last result
//   max_o, min_o      larger and smaller operand (only with MAG_CMP_MINMAX_EN)
// Configuration macro: MAG_CMP_MINMAX_EN adds the max_o/min_o outputs.
module seq_magnitude_comparator #(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int NW    = $clog2(NDIG) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [NW-1:0]    ndig_used
`ifdef MAG_CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o
`endif
);

  // Slice index needs at least one bit even for the single-slice case.
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [IW-1:0]    idx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic             slice_gt;
  logic             slice_lt;
  logic             last_slice;
  logic             decide;
  logic             accept;

  // Current slice of each latched operand. For signed operands the sign bit
  // lives in the top slice; flipping it maps two's complement ordering onto
  // unsigned ordering, so a plain unsigned compare works for every slice.
  always_comb begin
    a_sh    = a_q >> (int'(idx) * DIGIT);
    b_sh    = b_q >> (int'(idx) * DIGIT);
    slice_a = a_sh[DIGIT-1:0];
    slice_b = b_sh[DIGIT-1:0];
    if (sm_q && (idx == TOP_IDX)) begin
      slice_a[DIGIT-1] = ~slice_a[DIGIT-1];
      slice_b[DIGIT-1] = ~slice_b[DIGIT-1];
    end
    slice_gt   = (slice_a > slice_b);
    slice_lt   = (slice_a < slice_b);
    last_slice = (idx == '0);
  end

  assign decide = (state == CMP) && (slice_gt || slice_lt || last_slice);
  assign accept = start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMP;
      CMP:     if (decide) state_nxt = DONE;
      DONE:    state_nxt = start ? CMP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CMP);
  assign done = (state == DONE);

  // Operand capture, slice walk and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sm_q      <= 1'b0;
      idx       <= '0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      ndig_used <= '0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      sm_q      <= signed_mode;
      idx       <= TOP_IDX;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      ndig_used <= '0;
    end else if (state == CMP) begin
      ndig_used <= ndig_used + NW'(1);
      if (slice_gt) begin
        gt <= 1'b1;
      end else if (slice_lt) begin
        lt <= 1'b1;
      end else if (last_slice) begin
        eq <= 1'b1;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

`ifdef MAG_CMP_MINMAX_EN
  // Registered alongside gt/lt/eq; on equality both report the latched a.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_o <= '0;
      min_o <= '0;
    end else if (accept) begin
      max_o <= '0;
      min_o <= '0;
    end else if (decide) begin
      if (slice_lt) begin
        max_o <= b_q;
        min_o <= a_q;
      end else begin
        max_o <= a_q;
        min_o <= b_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NW    = $clog2(WIDTH / DIGIT) + 1;
  localparam int NV    = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [NW-1:0]    ndig_used;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sm;
    logic [15:0] va;
    logic [15:0] vb;
    logic        egt;
    logic        elt;
    logic        eeq;
    int          end_n;
  } vec_t;

  vec_t vec [NV];

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .gt         (gt),
    .lt         (lt),
    .eq         (eq),
    .ndig_used  (ndig_used)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for done with a bound; returns cycles counted after the accept edge.
  task automatic wait_done(output int lat, output int seen);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1;
    end
  endtask

  initial begin
    int lat;
    int seen;
    int pulses;

    vec[0]  = '{1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1};
    vec[1]  = '{1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 4};
    vec[2]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1};
    vec[3]  = '{1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1};
    vec[4]  = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vec[5]  = '{1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1};
    vec[6]  = '{1'b0, 16'h0012, 16'h0013, 1'b0, 1'b1, 1'b0, 4};
    vec[7]  = '{1'b1, 16'hFFFE, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4};
    vec[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4};
    vec[9]  = '{1'b0, 16'h1200, 16'h1300, 1'b0, 1'b1, 1'b0, 2};
    vec[10] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 4};
    vec[11] = '{1'b0, 16'h0100, 16'h00FF, 1'b1, 1'b0, 1'b0, 2};

    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_gt", int'(gt), 0);
    chk("rst_lt", int'(lt), 0);
    chk("rst_eq", int'(eq), 0);
    chk("rst_ndig", int'(ndig_used), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven compares
    for (int i = 0; i < NV; i++) begin
      signed_mode = vec[i].sm;
      a           = vec[i].va;
      b           = vec[i].vb;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      wait_done(lat, seen);
      chk($sformatf("v%0d_done_seen", i), seen, 1);
      chk($sformatf("v%0d_latency", i), lat, vec[i].end_n);
      chk($sformatf("v%0d_gt", i), int'(gt), int'(vec[i].egt));
      chk($sformatf("v%0d_lt", i), int'(lt), int'(vec[i].elt));
      chk($sformatf("v%0d_eq", i), int'(eq), int'(vec[i].eeq));
      chk($sformatf("v%0d_ndig", i), int'(ndig_used), vec[i].end_n);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_fall", i), int'(done), 0);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      chk($sformatf("v%0d_hold", i), int'({gt, lt, eq}),
          int'({vec[i].egt, vec[i].elt, vec[i].eeq}));
    end

    // start ignored while busy, accepted in the DONE cycle
    signed_mode = 1'b0;
    a           = 16'h12A0;
    b           = 16'h12B0;
    start       = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h0000;
    b = 16'hFFFF;
    wait_done(lat, seen);
    chk("ign_done_seen", seen, 1);
    chk("ign_latency", lat, 3);
    chk("ign_lt", int'(lt), 1);
    chk("ign_gt", int'(gt), 0);
    chk("ign_ndig", int'(ndig_used), 3);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_done", int'(done), 0);
    chk("b2b_cleared", int'({gt, lt, eq}), 0);
    chk("b2b_ndig_clr", int'(ndig_used), 0);
    wait_done(lat, seen);
    chk("b2b_done_seen", seen, 1);
    chk("b2b_latency", lat, 1);
    chk("b2b_lt", int'(lt), 1);
    chk("b2b_ndig", int'(ndig_used), 1);
    @(posedge clk);
    #1;

    // Reset during a compare aborts it without a done pulse
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_res", int'({gt, lt, eq}), 0);
    chk("abort_ndig", int'(ndig_used), 0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
